// File: rtl/axi_lite_regbank_slave.sv
// AXI-lite register bank responder: four byte-strobed RW control registers,
// a constant ID word, a free-running cycle counter and a sampled status word.
// Every access completes as OKAY. There are no response codes on this port.
module axi_lite_regbank_slave #(
  parameter logic [31:0] ID_VALUE  = 32'h4349_4430,
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_awvalid,
  output logic         s_awready,
  input  logic [31:0]  s_awaddr,
  input  logic [2:0]   s_awprot,
  input  logic         s_wvalid,
  output logic         s_wready,
  input  logic [31:0]  s_wdata,
  input  logic [3:0]   s_wstrb,
  output logic         s_bvalid,
  input  logic         s_bready,
  input  logic         s_arvalid,
  output logic         s_arready,
  input  logic [31:0]  s_araddr,
  input  logic [2:0]   s_arprot,
  output logic         s_rvalid,
  input  logic         s_rready,
  output logic [31:0]  s_rdata,
  input  logic [31:0]  hw_status,
  output logic [127:0] reg_out,
  output logic [3:0]   wr_pulse
);

  // Word indices within the 4 KiB window (offset[11:2]).
  localparam logic [9:0] IDX_ID     = 10'd4;
  localparam logic [9:0] IDX_CNT    = 10'd5;
  localparam logic [9:0] IDX_STATUS = 10'd6;

  logic [3:0][31:0] regs;
  logic [31:0]      cnt;

  logic             aw_held;
  logic [9:0]       aw_idx_q;
  logic             w_held;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  logic             commit;
  logic             commit_reg;
  logic             cnt_clr;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic [9:0]       ar_idx;
  logic [31:0]      rd_mux;

  // Address bits outside the decoded window and the protection fields carry
  // no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{s_awaddr[31:12], s_awaddr[1:0], s_awprot,
                         s_araddr[31:12], s_araddr[1:0], s_arprot};

  // A single write may be outstanding: each channel is blocked once its
  // holding register is full, and both are blocked while B is pending.
  assign s_awready = !aw_held && !s_bvalid;
  assign s_wready  = !w_held && !s_bvalid;
  assign s_arready = !s_rvalid;

  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign ar_hs  = s_arvalid && s_arready;
  assign ar_idx = s_araddr[11:2];

  assign commit     = aw_held && w_held && !s_bvalid;
  assign commit_reg = commit && (aw_idx_q < 10'd4);
  assign cnt_clr    = commit && (aw_idx_q == IDX_CNT) && (|w_strb_q);

  assign reg_out = regs;

  // Latch AW and W independently until both are present for the commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_awaddr[11:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
    end
  end

  // Commit the held write into the targeted RW register, byte lane by lane.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      regs <= {4{REG_RESET}};
    end else if (commit_reg) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) begin
          regs[aw_idx_q[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  // One-cycle strobe to the peripheral for each RW register commit,
  // raised even when no byte lane was enabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit_reg) begin
        wr_pulse[aw_idx_q[1:0]] <= 1'b1;
      end
    end
  end

  // Write response: raised at commit, held until the master takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_bvalid <= 1'b0;
    end else if (commit) begin
      s_bvalid <= 1'b1;
    end else if (s_bvalid && s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

  // Free-running cycle counter; a strobed write clears it and wins over
  // the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Read decode; unmapped offsets return zero.
  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      10'd0, 10'd1, 10'd2, 10'd3: rd_mux = regs[ar_idx[1:0]];
      IDX_ID:                     rd_mux = ID_VALUE;
      IDX_CNT:                    rd_mux = cnt;
      IDX_STATUS:                 rd_mux = hw_status;
      default:                    rd_mux = '0;
    endcase
  end

  // Read channel: data is captured at the AR handshake, so a write
  // committing on the same edge is not yet visible, and stays stable
  // until the R handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_mux;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Scoreboard bench for axi_lite_regbank_slave: stimulus pushes expected
// R/B responses, a negedge monitor pops and compares on each handshake.
module tb_axi_lite_regbank_slave;

  localparam logic [31:0] ID = 32'h4349_4430;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_awvalid, s_awready;
  logic [31:0]  s_awaddr;
  logic [2:0]   s_awprot;
  logic         s_wvalid, s_wready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_bvalid, s_bready;
  logic         s_arvalid, s_arready;
  logic [31:0]  s_araddr;
  logic [2:0]   s_arprot;
  logic         s_rvalid, s_rready;
  logic [31:0]  s_rdata;
  logic [31:0]  hw_status;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;

  axi_lite_regbank_slave dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .hw_status(hw_status), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // kind: 0 exact compare, 1 capture into cap_q, 2 expect value < 4
  typedef struct {
    logic [31:0] data;
    int          kind;
  } rexp_t;

  rexp_t       r_q[$];
  int          b_q[$];
  logic [31:0] cap_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor; inputs only change just after posedge, so negedge
  // values are what the next posedge will see.
  always @(negedge clk) begin
    if (resetn) begin
      if (s_rvalid && s_rready) begin
        chk("r_expected", 128'(r_q.size() > 0), 128'd1);
        if (r_q.size() > 0) begin
          rexp_t e;
          e = r_q.pop_front();
          if (e.kind == 0) chk("r_data", s_rdata, e.data);
          else if (e.kind == 1) cap_q.push_back(s_rdata);
          else chk("r_data_lt4", 128'(s_rdata < 32'd4), 128'd1);
        end
      end
      if (s_bvalid && s_bready) begin
        chk("b_expected", 128'(b_q.size() > 0), 128'd1);
        if (b_q.size() > 0) void'(b_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [31:0] a, input int kind, input logic [31:0] e);
    rexp_t x;
    x.data = e;
    x.kind = kind;
    r_q.push_back(x);
    s_araddr  = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 20 && !s_arready; i++) tick();
    chk("ar_ready", s_arready, 1);
    tick();
    s_arvalid = 1'b0;
    chk("r_latency", s_rvalid, 1);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, input bit expect_b);
    if (expect_b) b_q.push_back(1);
    s_awaddr = a;
    s_wdata  = d;
    s_wstrb  = s;
    if (lead > 0) begin
      s_wvalid = 1'b1;
      for (int i = 0; i < 20 && !s_wready; i++) tick();
      chk("w_ready", s_wready, 1);
      tick();
      s_wvalid = 1'b0;
      repeat (lead - 1) tick();
      chk("w_held_blocks", s_wready, 0);
      s_awvalid = 1'b1;
      for (int i = 0; i < 20 && !s_awready; i++) tick();
      chk("aw_ready", s_awready, 1);
      tick();
      s_awvalid = 1'b0;
    end else begin
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      for (int i = 0; i < 20 && !(s_awready && s_wready); i++) tick();
      chk("aw_w_ready", s_awready && s_wready, 1);
      tick();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    resetn = 0; s_awvalid = 0; s_awaddr = 0; s_awprot = 0; s_wvalid = 0; s_wdata = 0;
    s_wstrb = 0; s_bready = 1; s_arvalid = 0; s_araddr = 0; s_arprot = 0; s_rready = 1;
    hw_status = 32'h1234_5678;
    repeat (3) tick();
    chk("rst_awready", s_awready, 1);
    chk("rst_wready", s_wready, 1);
    chk("rst_arready", s_arready, 1);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    resetn = 1;
    tick();

    rd(32'h10, 0, ID);
    rd(32'h00, 0, 32'h0);

    // W leads AW by three cycles, partial strobes
    wr(32'h04, 32'hA5A5_1234, 4'b0101, 3, 1);
    chk("pulse_pre", wr_pulse, 4'b0000);
    tick();
    chk("pulse_reg1", wr_pulse, 4'b0010);
    chk("bvalid_reg1", s_bvalid, 1);
    chk("reg_out_reg1", reg_out[63:32], 32'h00A5_0034);
    tick();
    chk("pulse_end", wr_pulse, 4'b0000);
    rd(32'h04, 0, 32'h00A5_0034);

    // B backpressure
    s_bready = 0;
    wr(32'h08, 32'h1111_2222, 4'hF, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", s_bvalid, 1);
      chk("bp_awready", s_awready, 0);
      chk("bp_wready", s_wready, 0);
      tick();
    end
    s_bready = 1;
    tick();
    chk("bp_bvalid_clr", s_bvalid, 0);
    chk("bp_awready_back", s_awready, 1);
    wr(32'h0C, 32'hDEAD_BEEF, 4'b1100, 0, 1);
    tick();
    tick();
    chk("reg_out_reg3", reg_out[127:96], 32'hDEAD_0000);

    // read coinciding with commit sees the old value
    wr(32'h04, 32'h0BAD_F00D, 4'hF, 0, 1);
    rd(32'h04, 0, 32'h00A5_0034);
    rd(32'h04, 0, 32'h0BAD_F00D);

    // counter spacing and clear
    rd(32'h14, 1, 32'h0);
    repeat (8) tick();
    rd(32'h14, 1, 32'h0);
    chk("cnt_caps", cap_q.size(), 2);
    if (cap_q.size() == 2) chk("cnt_diff", cap_q[1] - cap_q[0], 32'd10);
    wr(32'h14, 32'hFFFF_FFFF, 4'hF, 0, 1);
    tick();
    rd(32'h14, 2, 32'h0);

    // status, unmapped, read-only and zero-strobe writes
    rd(32'h18, 0, 32'h1234_5678);
    rd(32'h1C, 0, 32'h0);
    rd(32'h800, 0, 32'h0);
    wr(32'h800, 32'hFFFF_FFFF, 4'hF, 0, 1);
    tick();
    chk("unmapped_pulse", wr_pulse, 4'b0000);
    chk("unmapped_bvalid", s_bvalid, 1);
    tick();
    wr(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 1);
    tick();
    tick();
    rd(32'h10, 0, ID);
    wr(32'h00, 32'hFFFF_FFFF, 4'b0000, 0, 1);
    tick();
    chk("zero_strb_pulse", wr_pulse, 4'b0001);
    tick();
    chk("regs_intact", reg_out, {32'hDEAD_0000, 32'h1111_2222, 32'h0BAD_F00D, 32'h0000_0000});

    // R stall with AR held, then reset mid-transfer
    s_bready = 0;
    wr(32'h00, 32'h5555_5555, 4'hF, 0, 0);
    tick();
    chk("stall_bvalid", s_bvalid, 1);
    s_rready  = 0;
    s_araddr  = 32'h10;
    s_arvalid = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_arready", s_arready, 0);
      chk("stall_rvalid", s_rvalid, 1);
      chk("stall_rdata", s_rdata, ID);
      tick();
    end
    resetn = 0;
    tick();
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_reg_out", reg_out, 0);
    chk("mid_rst_rdata", s_rdata, 0);
    s_arvalid = 0;
    s_rready  = 1;
    s_bready  = 1;
    resetn    = 1;
    tick();
    rd(32'h00, 0, 32'h0);
    rd(32'h0C, 0, 32'h0);

    repeat (4) tick();
    chk("r_q_drained", r_q.size(), 0);
    chk("b_q_drained", b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank_slave.md
Name: axi_lite_regbank_slave

Overview:
- AXI-lite responder that sits on one slave port (s0..s3) of the 1x4 AXI-lite interconnect and exposes a 4 KiB window of memory-mapped registers.
- Contents: four RW control registers with byte strobes, a read-only ID word, a free-running cycle counter (write clears it), and a sampled hardware status word.
- RW register contents and per-register write pulses are driven out to the attached peripheral logic.
- Signal subset matches the interconnect exactly: no BRESP/RRESP; every access completes as OKAY.

Parameters:
ID_VALUE, 32'h4349_4430, constant returned at offset 0x10.
REG_RESET, 32'h0000_0000, reset value of REG0..REG3.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
s_awvalid  input  1  write address valid
s_awready  output  1  write address ready
s_awaddr  input  32  write address; only [11:0] decoded
s_awprot  input  3  ignored
s_wvalid  input  1  write data valid
s_wready  output  1  write data ready
s_wdata  input  32  write data
s_wstrb  input  4  byte strobes
s_bvalid  output  1  write response valid
s_bready  input  1  write response ready
s_arvalid  input  1  read address valid
s_arready  output  1  read address ready
s_araddr  input  32  read address; only [11:0] decoded
s_arprot  input  3  ignored
s_rvalid  output  1  read data valid
s_rready  input  1  read data ready
s_rdata  output  32  read data
hw_status  input  32  status word, sampled for reads at 0x18
reg_out  output  128  {REG3,REG2,REG1,REG0}
wr_pulse  output  4  one-cycle pulse per REGn commit

Behaviour:
Register map (offset = addr[11:0]; addr[1:0] ignored):
- 0x00..0x0C: REG0..REG3, RW.
- 0x10: ID, RO.
- 0x14: CNT, counter.
- 0x18: STATUS, RO.
- 0x1C and 0x20..0xFFC: unmapped. Reads return 0; writes are accepted and discarded. Every access still gets a response.

Reset:
- s_awready=1, s_wready=1, s_arready=1.
- s_bvalid=0, s_rvalid=0, s_rdata=0.
- REG0..3=REG_RESET, CNT=0, wr_pulse=0.
- Any in-flight AW, W or R state is dropped without a response.

Write path:
- AW and W are accepted independently, in either order or in the same cycle, and each is latched into a holding register.
- s_awready = !aw_held && !s_bvalid.
- s_wready = !w_held && !s_bvalid.
- Commit happens on the first edge where aw_held && w_held && !s_bvalid. At that edge:
  - the target register updates per byte, only lanes with wstrb[i]=1;
  - s_bvalid sets;
  - aw_held and w_held clear;
  - wr_pulse[n] is high for exactly the following cycle if REGn was targeted, even when wstrb=0.
- Latency: a handshake on both channels at edge E0 gives s_bvalid visible after E1.
- s_bvalid holds until s_bready; the next AW/W is accepted only after the B handshake. At most one write is outstanding.
- A write to ID or STATUS has no effect.
- A write to CNT with any strobe bit set clears CNT to 0 at the commit edge.

Counter:
- CNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
- If a clear and an increment coincide, the clear wins (CNT=0).

Read path:
- s_arready = !s_rvalid.
- On an AR handshake at edge E0, s_rdata is loaded and s_rvalid sets, both visible after E0 (1-cycle latency).
- CNT and hw_status are snapshotted at E0.
- s_rdata stays stable while s_rvalid && !s_rready. The R handshake clears s_rvalid, and s_arready rises in the same cycle.
- Back-to-back reads: if s_rready stays high, one read completes every 2 cycles.

Concurrency:
- Read and write paths are fully independent.
- A read whose AR edge coincides with a write commit to the same register returns the pre-write value.

Test Plan:
- Reset, then read 0x10 -> s_rdata=0x4349_4430, s_rvalid one cycle after the AR handshake; read 0x00 -> 0.
- W issued 3 cycles before AW, addr 0x04, data 0xA5A5_1234, strb 4'b0101 -> REG1=0x00A5_0034, wr_pulse=4'b0010 for one cycle, reg_out[63:32] matches, one B response.
- AW+W addr 0x08 with s_bready held low 5 cycles -> s_bvalid stays high and s_awready/s_wready stay 0 until the B handshake; a second write is then accepted.
- Read 0x14 twice, 10 cycles apart -> difference 10 (read spacing); write 0x14 strb 4'hF -> an immediate read returns a small value (< 4).
- Read 0x1C and 0x800, write 0x800 -> reads return 0, write gets s_bvalid, REG0..3 unchanged.
- s_rready held low with s_arvalid held high -> s_arready=0 and s_rdata stable; assert resetn=0 mid-transfer -> s_rvalid=0 and s_bvalid=0 next cycle, all registers at their reset values.
